// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// Decode-to-execute pipeline register. It latches the decoded control bits,
// operands and register indices into the EX stage. It detects load-use
// hazards against the instruction already in EX and inserts a bubble on a
// hazard, on a branch/jump flush, or when ID is empty. Two saturating
// counters record stall and flush cycles for performance debug.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   valid_d          : ID stage holds a real instruction
//   *_d              : decoded control bits, register indices, operands
//   flush_e          : branch taken / jump resolved, kill the ID instruction
//   valid_e, *_e     : registered EX-stage copy of the ID fields
//   wr_reg_e         : destination register (rd_e or rt_e), combinational
//   stall_out        : hold PC and IF/ID this cycle, combinational
//   load_use_cnt     : saturating count of load-use stall edges
//   flush_cnt        : saturating count of flush edges
// ----------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // ID stage
  input  logic              valid_d,
  input  logic              jump_d,
  input  logic              beq_d,
  input  logic              mem_to_reg_d,
  input  logic              mem_write_d,
  input  logic              alu_src_d,
  input  logic              reg_write_d,
  input  logic              reg_dest_d,
  input  logic [2:0]        alu_op_d,
  input  logic              uses_rs_d,
  input  logic              uses_rt_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] imm_d,
  input  logic [DATA_W-1:0] pc_plus4_d,
  input  logic              flush_e,
  // EX stage
  output logic              valid_e,
  output logic              jump_e,
  output logic              beq_e,
  output logic              mem_to_reg_e,
  output logic              mem_write_e,
  output logic              alu_src_e,
  output logic              reg_write_e,
  output logic              reg_dest_e,
  output logic [2:0]        alu_op_e,
  output logic [REG_AW-1:0] rs_e,
  output logic [REG_AW-1:0] rt_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] imm_e,
  output logic [DATA_W-1:0] pc_plus4_e,
  output logic [REG_AW-1:0] wr_reg_e,
  // Hazard / debug
  output logic              stall_out,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned CTRL_W = 10;

  // Pipeline register state
  logic              valid_q,    valid_d_n;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [REG_AW-1:0] rs_q,       rs_nx;
  logic [REG_AW-1:0] rt_q,       rt_nx;
  logic [REG_AW-1:0] rd_q,       rd_nx;
  logic [DATA_W-1:0] rd1_q,      rd1_nx;
  logic [DATA_W-1:0] rd2_q,      rd2_nx;
  logic [DATA_W-1:0] imm_q,      imm_nx;
  logic [DATA_W-1:0] pc4_q,      pc4_nx;
  logic [CNT_W-1:0]  lu_cnt_q,   lu_cnt_d;
  logic [CNT_W-1:0]  fl_cnt_q,   fl_cnt_d;

  logic              load_use_c;
  logic              rs_hit_c;
  logic              rt_hit_c;
  logic              capture_c;

  // Control field slicing: {jump, beq, mem_to_reg, mem_write, alu_src,
  // reg_write, reg_dest, alu_op[2:0]}
  logic              ex_mem_to_reg_c;
  logic              ex_reg_write_c;
  assign ex_mem_to_reg_c = ctrl_q[7];
  assign ex_reg_write_c  = ctrl_q[4];

  // Load-use detection against the load sitting in EX; $zero is never a hazard
  always_comb begin
    rs_hit_c   = uses_rs_d && (rs_d == rt_q);
    rt_hit_c   = uses_rt_d && (rt_d == rt_q);
    load_use_c = valid_d && valid_q && ex_mem_to_reg_c && ex_reg_write_c &&
                 (rt_q != '0) && (rs_hit_c || rt_hit_c);
  end

  // A flush kills the ID instruction, so it overrides the stall request
  assign stall_out = load_use_c && !flush_e;

  assign capture_c = !flush_e && !load_use_c && valid_d;

  // Next-state: bubble by default, capture ID only when nothing blocks it
  always_comb begin
    valid_d_n = 1'b0;
    ctrl_d    = '0;
    rs_nx     = '0;
    rt_nx     = '0;
    rd_nx     = '0;
    rd1_nx    = '0;
    rd2_nx    = '0;
    imm_nx    = '0;
    pc4_nx    = '0;
    if (capture_c) begin
      valid_d_n = 1'b1;
      ctrl_d    = {jump_d, beq_d, mem_to_reg_d, mem_write_d, alu_src_d,
                   reg_write_d, reg_dest_d, alu_op_d};
      rs_nx     = rs_d;
      rt_nx     = rt_d;
      rd_nx     = rd_d;
      rd1_nx    = rd1_d;
      rd2_nx    = rd2_d;
      imm_nx    = imm_d;
      pc4_nx    = pc_plus4_d;
    end
  end

  // Saturating event counters; a flush edge is never also counted as a stall
  always_comb begin
    fl_cnt_d = fl_cnt_q;
    lu_cnt_d = lu_cnt_q;
    if (flush_e) begin
      if (fl_cnt_q != '1) fl_cnt_d = fl_cnt_q + CNT_W'(1);
    end else if (load_use_c) begin
      if (lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
  end

  // State register; reset discards any in-flight EX instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d_n;
      ctrl_q   <= ctrl_d;
      rs_q     <= rs_nx;
      rt_q     <= rt_nx;
      rd_q     <= rd_nx;
      rd1_q    <= rd1_nx;
      rd2_q    <= rd2_nx;
      imm_q    <= imm_nx;
      pc4_q    <= pc4_nx;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign valid_e      = valid_q;
  assign jump_e       = ctrl_q[9];
  assign beq_e        = ctrl_q[8];
  assign mem_to_reg_e = ctrl_q[7];
  assign mem_write_e  = ctrl_q[6];
  assign alu_src_e    = ctrl_q[5];
  assign reg_write_e  = ctrl_q[4];
  assign reg_dest_e   = ctrl_q[3];
  assign alu_op_e     = ctrl_q[2:0];
  assign rs_e         = rs_q;
  assign rt_e         = rt_q;
  assign rd_e         = rd_q;
  assign rd1_e        = rd1_q;
  assign rd2_e        = rd2_q;
  assign imm_e        = imm_q;
  assign pc_plus4_e   = pc4_q;
  assign load_use_cnt = lu_cnt_q;
  assign flush_cnt    = fl_cnt_q;

  // Destination register select for the writeback path
  assign wr_reg_e = ctrl_q[3] ? rd_q : rt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Self-checking bench for id_ex_pipe_reg (CNT_W=4 so saturation is reachable).
// A reference model holds the expected EX-stage record and counters; every
// cycle the stall output and all EX outputs are compared against it.
// ----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              valid_d, jump_d, beq_d, mem_to_reg_d, mem_write_d;
  logic              alu_src_d, reg_write_d, reg_dest_d;
  logic [2:0]        alu_op_d;
  logic              uses_rs_d, uses_rt_d;
  logic [REG_AW-1:0] rs_d, rt_d, rd_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d, pc_plus4_d;
  logic              flush_e;

  logic              valid_e, jump_e, beq_e, mem_to_reg_e, mem_write_e;
  logic              alu_src_e, reg_write_e, reg_dest_e;
  logic [2:0]        alu_op_e;
  logic [REG_AW-1:0] rs_e, rt_e, rd_e, wr_reg_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, imm_e, pc_plus4_e;
  logic              stall_out;
  logic [CNT_W-1:0]  load_use_cnt, flush_cnt;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .valid_d(valid_d), .jump_d(jump_d), .beq_d(beq_d),
    .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
    .alu_src_d(alu_src_d), .reg_write_d(reg_write_d), .reg_dest_d(reg_dest_d),
    .alu_op_d(alu_op_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_plus4_d(pc_plus4_d),
    .flush_e(flush_e),
    .valid_e(valid_e), .jump_e(jump_e), .beq_e(beq_e),
    .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .reg_write_e(reg_write_e), .reg_dest_e(reg_dest_e),
    .alu_op_e(alu_op_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_plus4_e(pc_plus4_e),
    .wr_reg_e(wr_reg_e), .stall_out(stall_out),
    .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  // Expected contents of the EX stage
  typedef struct {
    bit       valid;
    bit       jump, beq, m2r, mw, as, rw, rdst;
    bit [2:0] op;
    int       rs, rt, rd;
    bit [31:0] rd1, rd2, imm, pc4;
  } ex_t;

  ex_t exp_ex;
  int  exp_lu;
  int  exp_fl;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic ex_t empty_ex();
    ex_t e;
    e.valid = 0; e.jump = 0; e.beq = 0; e.m2r = 0; e.mw = 0; e.as = 0;
    e.rw = 0; e.rdst = 0; e.op = 0; e.rs = 0; e.rt = 0; e.rd = 0;
    e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc4 = 0;
    return e;
  endfunction

  // A load in EX that writes a nonzero register the ID instruction reads
  function automatic bit hazard();
    bit reads;
    reads = (uses_rs_d && int'(rs_d) == exp_ex.rt) ||
            (uses_rt_d && int'(rt_d) == exp_ex.rt);
    return valid_d && exp_ex.valid && exp_ex.m2r && exp_ex.rw &&
           exp_ex.rt != 0 && reads;
  endfunction

  task automatic check_ex(input string tag);
    int wr;
    wr = exp_ex.rdst ? exp_ex.rd : exp_ex.rt;
    chk({tag, ".valid"}, 128'(valid_e), 128'(exp_ex.valid));
    chk({tag, ".ctrl"},
        128'({jump_e, beq_e, mem_to_reg_e, mem_write_e, alu_src_e,
              reg_write_e, reg_dest_e, alu_op_e}),
        128'({exp_ex.jump, exp_ex.beq, exp_ex.m2r, exp_ex.mw, exp_ex.as,
              exp_ex.rw, exp_ex.rdst, exp_ex.op}));
    chk({tag, ".idx"}, 128'({rs_e, rt_e, rd_e, wr_reg_e}),
        128'({5'(exp_ex.rs), 5'(exp_ex.rt), 5'(exp_ex.rd), 5'(wr)}));
    chk({tag, ".data"}, {rd1_e, rd2_e, imm_e, pc_plus4_e},
        {exp_ex.rd1, exp_ex.rd2, exp_ex.imm, exp_ex.pc4});
    chk({tag, ".cnt"}, 128'({load_use_cnt, flush_cnt}),
        128'({4'(exp_lu), 4'(exp_fl)}));
  endtask

  // One clock: check stall before the edge, advance model, check after
  task automatic cycle(input string tag);
    bit   lu;
    ex_t  nxt;
    #1;
    lu = hazard();
    chk({tag, ".stall"}, 128'(stall_out), 128'(lu && !flush_e));
    nxt = empty_ex();
    if (!rst && !flush_e && !lu && valid_d) begin
      nxt.valid = 1; nxt.jump = jump_d; nxt.beq = beq_d; nxt.m2r = mem_to_reg_d;
      nxt.mw = mem_write_d; nxt.as = alu_src_d; nxt.rw = reg_write_d;
      nxt.rdst = reg_dest_d; nxt.op = alu_op_d;
      nxt.rs = int'(rs_d); nxt.rt = int'(rt_d); nxt.rd = int'(rd_d);
      nxt.rd1 = rd1_d; nxt.rd2 = rd2_d; nxt.imm = imm_d; nxt.pc4 = pc_plus4_d;
    end
    @(posedge clk);
    if (rst) begin
      exp_lu = 0; exp_fl = 0;
    end else if (flush_e) begin
      if (exp_fl < CNT_MAX) exp_fl++;
    end else if (lu) begin
      if (exp_lu < CNT_MAX) exp_lu++;
    end
    exp_ex = nxt;
    #1;
    check_ex(tag);
  endtask

  task automatic id_clear();
    valid_d = 0; jump_d = 0; beq_d = 0; mem_to_reg_d = 0; mem_write_d = 0;
    alu_src_d = 0; reg_write_d = 0; reg_dest_d = 0; alu_op_d = 0;
    uses_rs_d = 0; uses_rt_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
    rd1_d = 0; rd2_d = 0; imm_d = 0; pc_plus4_d = 0; flush_e = 0;
  endtask

  task automatic id_add(input int rs, input int rt, input int rd);
    id_clear();
    valid_d = 1; reg_write_d = 1; reg_dest_d = 1; alu_op_d = 3'b010;
    uses_rs_d = 1; uses_rt_d = 1;
    rs_d = 5'(rs); rt_d = 5'(rt); rd_d = 5'(rd);
    rd1_d = 32'd5; rd2_d = 32'd7; pc_plus4_d = 32'h0000_0104;
  endtask

  task automatic id_lw(input int rt);
    id_clear();
    valid_d = 1; mem_to_reg_d = 1; reg_write_d = 1; alu_src_d = 1;
    uses_rs_d = 1; rs_d = 5'd1; rt_d = 5'(rt); imm_d = 32'h10;
    rd1_d = 32'h1000; pc_plus4_d = 32'h0000_0200;
  endtask

  task automatic id_random();
    valid_d      = ($urandom_range(0, 3) != 0);
    jump_d       = 1'($urandom);
    beq_d        = 1'($urandom);
    mem_to_reg_d = 1'($urandom);
    mem_write_d  = 1'($urandom);
    alu_src_d    = 1'($urandom);
    reg_write_d  = ($urandom_range(0, 3) != 0);
    reg_dest_d   = 1'($urandom);
    alu_op_d     = 3'($urandom);
    uses_rs_d    = 1'($urandom);
    uses_rt_d    = 1'($urandom);
    rs_d         = 5'($urandom_range(0, 3));
    rt_d         = 5'($urandom_range(0, 3));
    rd_d         = 5'($urandom);
    rd1_d        = $urandom;
    rd2_d        = $urandom;
    imm_d        = $urandom;
    pc_plus4_d   = $urandom;
    flush_e      = ($urandom_range(0, 7) == 0);
    rst          = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    // Reset: first edge establishes known state
    id_clear();
    rst = 1;
    @(posedge clk);
    #1;
    exp_ex = empty_ex(); exp_lu = 0; exp_fl = 0;
    check_ex("reset0");
    cycle("reset1");
    rst = 0;

    // Pass-through of an add
    id_add(1, 2, 3);
    cycle("add");
    chk("add.wr_reg", 128'(wr_reg_e), 128'(3));

    // Load-use stall, then capture after one bubble
    id_lw(8);
    cycle("lw8");
    id_add(8, 9, 10); uses_rt_d = 0;
    cycle("lu_bubble");
    chk("lu_bubble.cnt1", 128'(load_use_cnt), 128'(1));
    cycle("lu_capture");
    chk("lu_capture.valid", 128'(valid_e), 128'(1));

    // rt=0 load never hazards
    id_lw(0);
    cycle("lw0");
    id_add(0, 0, 4);
    cycle("zero_reader");

    // Matching index but operand not read
    id_lw(8);
    cycle("lw8b");
    id_add(8, 8, 5); uses_rs_d = 0; uses_rt_d = 0;
    cycle("unused_match");

    // Flush overrides a simultaneous load-use
    id_lw(8);
    cycle("lw8c");
    id_add(8, 1, 6); flush_e = 1;
    cycle("flush_pri");
    chk("flush_pri.fl", 128'(flush_cnt), 128'(1));

    // Invalid ID instruction becomes a bubble
    id_clear();
    reg_write_d = 1; mem_write_d = 1;
    cycle("invalid_id");

    // Flush counter saturation
    id_add(1, 2, 3); flush_e = 1;
    for (int i = 0; i < 20; i++) cycle("flush_sat");
    chk("flush_sat.max", 128'(flush_cnt), 128'(CNT_MAX));

    // Mid-run reset with a valid instruction in EX
    flush_e = 0;
    cycle("pre_rst");
    rst = 1;
    cycle("mid_rst");
    rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_random();
      cycle("rand");
    end

    // Load-use counter saturation with a held hazard that keeps re-arming
    id_clear(); rst = 0;
    for (int i = 0; i < 20; i++) begin
      id_lw(8);
      cycle("lu_sat_lw");
      id_add(8, 1, 2);
      cycle("lu_sat_stall");
    end
    chk("lu_sat.max", 128'(load_use_cnt), 128'(CNT_MAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
